// File: rtl/pot_line_emulator.sv
// Paddle/potentiometer emulation for line-counting video chips.
// Each channel loads a line count at the start of every frame. The count then
// runs down on horizontal sync, and pot_out flags the line where it reaches zero.
module pot_line_emulator #(
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned POS_W        = 8,
   parameter int unsigned SPEED_W      = 4,
   parameter int unsigned CENTER       = 128,
   parameter int unsigned ACCEL_FRAMES = 8
) (
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic                      hs,
   input  logic                      vs,
   input  logic [2*NUM_CH-1:0]       mode,
   input  logic [NUM_CH-1:0]         invert,
   input  logic [SPEED_W*NUM_CH-1:0] speed,
   input  logic [NUM_CH-1:0]         btn_up,
   input  logic [NUM_CH-1:0]         btn_down,
   input  logic [16*NUM_CH-1:0]      analog,
   input  logic [8*NUM_CH-1:0]       paddle,
   output logic [NUM_CH-1:0]         pot_out,
   output logic [POS_W*NUM_CH-1:0]   pos
);

   localparam int unsigned HOLD_W = $clog2(ACCEL_FRAMES + 1);
   localparam int unsigned EXT_W  = POS_W + 1;
   localparam logic [EXT_W-1:0] MAX_EXT = {1'b0, {POS_W{1'b1}}};

   typedef enum logic [1:0] {
      SRC_DIG = 2'b00,
      SRC_Y   = 2'b01,
      SRC_X   = 2'b10,
      SRC_PAD = 2'b11
   } src_e;

   logic vs_d, hs_d;
   logic vs_rise, hs_rise;

   assign vs_rise = vs & ~vs_d;
   assign hs_rise = hs & ~hs_d;

   // Sync edge detectors shared by all channels
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vs_d <= 1'b0;
         hs_d <= 1'b0;
      end else begin
         vs_d <= vs;
         hs_d <= hs;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      src_e               mode_g;
      logic [7:0]         a_y, a_x, pad;
      logic [SPEED_W-1:0] spd;
      logic [POS_W-1:0]   cnt_q, cnt_n, pos_q, pos_n, src;
      logic [HOLD_W-1:0]  hold_q, hold_n;
      logic               dir_q, dir_n;
      logic               up_only, dn_only, rev, accel;
      logic [EXT_W-1:0]   step, pos_ext, sum_dn;

      assign mode_g = src_e'(mode[2*g +: 2]);
      assign a_y    = analog[16*g+8 +: 8];
      assign a_x    = analog[16*g +: 8];
      assign pad    = paddle[8*g +: 8];
      assign spd    = speed[SPEED_W*g +: SPEED_W];

      // Frame-start source value; signed stick axes are offset to unsigned
      always_comb begin
         src = pos_q;
         case (mode_g)
            SRC_Y:   src = POS_W'({~a_y[7], a_y[6:0]}) << (POS_W - 8);
            SRC_X:   src = POS_W'({~a_x[7], a_x[6:0]}) << (POS_W - 8);
            SRC_PAD: src = POS_W'(pad) << (POS_W - 8);
            default: src = pos_q;
         endcase
      end

      // Next count, position and acceleration state; a reversal restarts acceleration
      always_comb begin
         cnt_n   = cnt_q;
         pos_n   = pos_q;
         hold_n  = hold_q;
         dir_n   = dir_q;
         up_only = btn_up[g] & ~btn_down[g];
         dn_only = btn_down[g] & ~btn_up[g];
         rev     = (up_only | dn_only) && (hold_q != '0) && (dn_only != dir_q);
         accel   = !rev && (hold_q >= HOLD_W'(ACCEL_FRAMES));
         step    = accel ? EXT_W'({spd, 1'b0}) : EXT_W'(spd);
         pos_ext = {1'b0, pos_q};
         sum_dn  = pos_ext + step;
         if (vs_rise) begin
            cnt_n = src ^ {POS_W{invert[g]}};
            if (mode_g == SRC_DIG) begin
               if (up_only) begin
                  pos_n = (pos_ext < step) ? '0 : POS_W'(pos_ext - step);
               end else if (dn_only) begin
                  pos_n = (sum_dn > MAX_EXT) ? '1 : POS_W'(sum_dn);
               end
               if (up_only | dn_only) begin
                  dir_n  = dn_only;
                  if (rev) begin
                     hold_n = HOLD_W'(1);
                  end else if (hold_q >= HOLD_W'(ACCEL_FRAMES)) begin
                     hold_n = HOLD_W'(ACCEL_FRAMES);
                  end else begin
                     hold_n = hold_q + HOLD_W'(1);
                  end
               end else begin
                  hold_n = '0;
               end
            end
         end else if (hs_rise && (cnt_q != '0)) begin
            cnt_n = cnt_q - POS_W'(1);
         end
      end

      // Channel state registers
      always_ff @(posedge clk_sys) begin
         if (reset) begin
            cnt_q  <= '0;
            pos_q  <= POS_W'(CENTER);
            hold_q <= '0;
            dir_q  <= 1'b0;
         end else begin
            cnt_q  <= cnt_n;
            pos_q  <= pos_n;
            hold_q <= hold_n;
            dir_q  <= dir_n;
         end
      end

      assign pot_out[g]           = (cnt_q == '0);
      assign pos[POS_W*g +: POS_W] = pos_q;
   end

endmodule

// File: tb/tb_pot_line_emulator.sv
// Randomised scoreboard bench for pot_line_emulator (2 channels, 8-bit).
// The reference model predicts every change of pot_out/pos with its cycle;
// an independent monitor matches observed output changes against that queue.
module tb_pot_line_emulator;

   logic        clk_sys = 1'b0;
   logic        reset, hs, vs;
   logic [3:0]  mode;
   logic [1:0]  invert, btn_up, btn_down, pot_out;
   logic [7:0]  speed;
   logic [31:0] analog;
   logic [15:0] paddle, pos;

   always #5 clk_sys = ~clk_sys;

   pot_line_emulator #(
      .NUM_CH(2), .POS_W(8), .SPEED_W(4), .CENTER(128), .ACCEL_FRAMES(8)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .mode(mode),
      .invert(invert), .speed(speed), .btn_up(btn_up), .btn_down(btn_down),
      .analog(analog), .paddle(paddle), .pot_out(pot_out), .pos(pos)
   );

   typedef struct {
      int cyc;
      int ch;
      int kind;   // 0 = pot_out, 1 = pos
      int val;
   } ev_t;

   ev_t evq[$];
   int  checks = 0, failures = 0, cyc = 0;
   bit  mon_en = 1'b0;

   // reference model state
   int m_pos[2], m_cnt[2], m_hold[2], m_dir[2], e_pot[2], e_pos[2];
   int m_vsd, m_hsd;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_cnt[c] = 0; m_pos[c] = 128; m_hold[c] = 0; m_dir[c] = 0;
      end
      m_vsd = 0; m_hsd = 0;
   endtask

   // Effect of the coming clock edge with the inputs currently driven
   task automatic model_step();
      int vr, hr, s, up, dn, spd, rv, st, base;
      logic [7:0] ay, ax;
      if (reset) begin
         model_reset();
      end else begin
         vr = (vs && !m_vsd) ? 1 : 0;
         hr = (hs && !m_hsd) ? 1 : 0;
         for (int c = 0; c < 2; c++) begin
            if (vr != 0) begin
               ay = analog[16*c+8 +: 8];
               ax = analog[16*c +: 8];
               case (mode[2*c +: 2])
                  2'd0:    s = m_pos[c];
                  2'd1:    s = int'($signed(ay)) + 128;
                  2'd2:    s = int'($signed(ax)) + 128;
                  default: s = int'(paddle[8*c +: 8]);
               endcase
               m_cnt[c] = invert[c] ? 255 - s : s;
               if (mode[2*c +: 2] == 2'd0) begin
                  up  = int'(btn_up[c]);
                  dn  = int'(btn_down[c]);
                  spd = int'(speed[4*c +: 4]);
                  if (up == dn) begin
                     m_hold[c] = 0;
                  end else begin
                     rv   = (m_hold[c] > 0 && dn != m_dir[c]) ? 1 : 0;
                     base = (rv != 0) ? 0 : m_hold[c];
                     st   = (base >= 8) ? 2 * spd : spd;
                     if (up != 0) m_pos[c] = (m_pos[c] - st < 0) ? 0 : m_pos[c] - st;
                     else         m_pos[c] = (m_pos[c] + st > 255) ? 255 : m_pos[c] + st;
                     m_hold[c] = (rv != 0) ? 1 : ((m_hold[c] + 1 > 8) ? 8 : m_hold[c] + 1);
                     m_dir[c]  = dn;
                  end
               end
            end else if (hr != 0 && m_cnt[c] > 0) begin
               m_cnt[c] = m_cnt[c] - 1;
            end
         end
         m_vsd = int'(vs);
         m_hsd = int'(hs);
      end
      for (int c = 0; c < 2; c++) begin
         s = (m_cnt[c] == 0) ? 1 : 0;
         if (s != e_pot[c]) evq.push_back('{cyc + 1, c, 0, s});
         e_pot[c] = s;
         if (m_pos[c] != e_pos[c]) evq.push_back('{cyc + 1, c, 1, m_pos[c]});
         e_pos[c] = m_pos[c];
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk_sys);
      #1;
      cyc++;
   endtask

   task automatic missed_before(input int limit);
      while (evq.size() > 0 && evq[0].cyc < limit) begin
         checks++;
         failures++;
         $display("FAIL missed_event ch=%0d kind=%0d actual=no-change required=%0d at cycle %0d",
                  evq[0].ch, evq[0].kind, evq[0].val, evq[0].cyc);
         void'(evq.pop_front());
      end
   endtask

   // Monitor: every observed output change must match a predicted event
   initial begin
      int prev[2][2];
      int act, idx;
      for (int c = 0; c < 2; c++) begin prev[c][0] = 1; prev[c][1] = 128; end
      forever begin
         @(negedge clk_sys);
         if (mon_en) begin
            missed_before(cyc);
            for (int c = 0; c < 2; c++) begin
               for (int k = 0; k < 2; k++) begin
                  act = (k == 0) ? int'(pot_out[c]) : int'(pos[8*c +: 8]);
                  if (act != prev[c][k]) begin
                     idx = -1;
                     foreach (evq[i])
                        if (idx < 0 && evq[i].cyc == cyc && evq[i].ch == c && evq[i].kind == k) idx = i;
                     if (idx < 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_change ch=%0d kind=%0d actual=%0d required=%0d (cycle %0d)",
                                 c, k, act, prev[c][k], cyc);
                     end else begin
                        check((k == 0) ? "pot_out_event" : "pos_event", act, evq[idx].val);
                        evq.delete(idx);
                     end
                     prev[c][k] = act;
                  end
               end
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_pot_out"}, int'(pot_out), 3);
      check({tag, "_pos0"}, int'(pos[7:0]), 128);
      check({tag, "_pos1"}, int'(pos[15:8]), 128);
   endtask

   // One frame: optional vs/hs coincidence, optional reset before line rst_at
   task automatic frame(input int lines, input bit coincide, input int rst_at, input bit mid_rand);
      if (!coincide) begin vs = 1'b1; hs = 1'b0; cycle(); end
      for (int l = 0; l < lines; l++) begin
         if (l == rst_at) begin
            reset = 1'b1; vs = 1'b0; hs = 1'b0;
            cycle();
            reset = 1'b0;
            check_reset_state("midreset");
         end
         if (mid_rand && l == lines / 2) begin
            mode = 4'($urandom); invert = 2'($urandom); speed = 8'($urandom);
            btn_up = 2'($urandom); btn_down = 2'($urandom);
         end
         vs = (l < 2); hs = 1'b1; cycle();
         hs = 1'b0; cycle();
      end
      vs = 1'b0; hs = 1'b0;
      cycle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; hs = 1'b0; vs = 1'b0; mode = 4'b0000; invert = 2'b00;
      speed = 8'h55; btn_up = 2'b00; btn_down = 2'b00; analog = '0; paddle = '0;
      model_reset();
      for (int c = 0; c < 2; c++) begin e_pot[c] = 1; e_pos[c] = 128; end
      repeat (3) cycle();
      reset = 1'b0;
      mon_en = 1'b1;
      check_reset_state("reset");

      // centred digital count: pot_out after 128 lines
      frame(140, 1'b0, -1, 1'b0);
      frame(140, 1'b0, -1, 1'b0);

      // up held on both channels: step 5, doubles after 8 frames, clamps at 0
      btn_up = 2'b11;
      repeat (30) frame(20, 1'b0, -1, 1'b0);
      check("clamp_pos0", int'(pos[7:0]), 0);
      check("clamp_pos1", int'(pos[15:8]), 0);

      // both held: frozen, acceleration cleared; then down only for 8 frames at step 5
      btn_down = 2'b11;
      repeat (3) frame(20, 1'b0, -1, 1'b0);
      check("both_held_pos0", int'(pos[7:0]), 0);
      btn_up = 2'b00;
      repeat (8) frame(20, 1'b0, -1, 1'b0);
      check("down8_pos0", int'(pos[7:0]), 40);
      check("down8_pos1", int'(pos[15:8]), 40);
      btn_down = 2'b00;

      // stick Y extremes on channel 0
      mode = 4'b0001; analog[15:8] = 8'h80;
      frame(30, 1'b0, -1, 1'b0);
      check("y80_pot0", int'(pot_out[0]), 1);
      analog[15:8] = 8'h7F; invert = 2'b01;
      frame(30, 1'b0, -1, 1'b0);
      check("y7f_inv_pot0", int'(pot_out[0]), 1);
      invert = 2'b00;

      // paddle with coincident vs/hs: load wins
      mode = 4'b1111; paddle = {8'd200, 8'd40};
      frame(60, 1'b1, -1, 1'b0);

      // reset after 20 lines, then a normal frame
      mode = 4'b0000; btn_down = 2'b01;
      frame(60, 1'b0, 20, 1'b0);
      btn_down = 2'b00;
      frame(140, 1'b0, -1, 1'b0);

      // randomised frames
      for (int f = 0; f < 30; f++) begin
         mode = 4'($urandom); invert = 2'($urandom); speed = 8'($urandom);
         btn_up = 2'($urandom); btn_down = 2'($urandom);
         analog = 32'($urandom); paddle = 16'($urandom);
         frame(int'($urandom_range(300, 3)), 1'($urandom), ($urandom_range(7, 0) == 0) ? int'($urandom_range(40, 3)) : -1, 1'b1);
      end

      repeat (4) cycle();
      missed_before(cyc + 1);
      check("events_left", evq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
